// File: rtl/apb_ucpd_pkg.sv
// apb_ucpd_pkg -- shared widths, prescaler decode and reset constants for the UCPD tick chain. Rev 1.0
`default_nettype none
package apb_ucpd_pkg;

  localparam int HBIT_W_DEF = 6;
  localparam int GAP_W_DEF  = 5;
  localparam int PSC_W_DEF  = 3;

  localparam logic RST_TICK  = 1'b0;
  localparam logic RST_PHASE = 1'b0;

  // Prescaler select n divides by 2^n; returns the terminal count (period - 1).
  function automatic logic [31:0] psc_decode(input logic [31:0] psc);
    return (32'd1 << psc) - 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_ucpd_tick_div.sv
// apb_ucpd_tick_div -- enable-qualified modulo counter with sync clear and registered tick. Rev 1.0
`default_nettype none
module apb_ucpd_tick_div
  import apb_ucpd_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         ic_clk,
  input  logic         ic_rst_n,
  input  logic         en_in,
  input  logic         clr,
  input  logic [W-1:0] tc,
  output logic         fire,
  output logic         tick
);

  logic [W-1:0] cnt;

  // fire is the combinational terminal hit, letting a following stage tick on the same edge.
  assign fire = en_in & ~clr & (cnt >= tc);

  always_ff @(posedge ic_clk or negedge ic_rst_n) begin
    if (!ic_rst_n) begin
      cnt  <= '0;
      tick <= RST_TICK;
    end else if (clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= fire;
      if (en_in) begin
        cnt <= (cnt >= tc) ? '0 : cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/apb_ucpd_tick_gen.sv
// apb_ucpd_tick_gen -- UCPD prescaler, half-bit/bit ticks, ifrgap and transwin timers.
// Define UCPD_HBIT_DITHER_EN to add fractional half-bit dithering via hbit_frac. Rev 1.0
`default_nettype none
module apb_ucpd_tick_gen
  import apb_ucpd_pkg::*;
#(
  parameter int HBIT_W = HBIT_W_DEF,
  parameter int GAP_W  = GAP_W_DEF,
  parameter int PSC_W  = PSC_W_DEF
) (
  input  logic              ic_clk,
  input  logic              ic_rst_n,
  input  logic              enable,
  input  logic [PSC_W-1:0]  psc_usbpdclk,
  input  logic [HBIT_W-1:0] hbitclkdiv,
  input  logic [3:0]        hbit_frac,
  input  logic [GAP_W-1:0]  transwin,
  input  logic [GAP_W-1:0]  ifrgap,
  input  logic              transmit_en,
  input  logic              wait_en,
  input  logic              bmc_en,
  input  logic              rx_wait_en,
  input  logic              ic_cc_in,
  input  logic              tx_eop_cmplt,
  input  logic              tx_sop_rst_cmplt,
  output logic              ucpd_tick,
  output logic              hbit_tick,
  output logic              bit_tick,
  output logic              bit_phase,
  output logic              transwin_en,
  output logic              ifrgap_en
);

  localparam int PCNT_W = (1 << PSC_W) - 1;

  logic [PSC_W-1:0]  psc_q;
  logic              psc_vld;
  logic              tx_q;
  logic              psc_chg;
  logic              tx_chg;
  logic              ucpd_fire;
  logic              hbit_fire;
  logic              hbit_ext;
  logic              ifg_qual;
  logic [PCNT_W-1:0] psc_tc;
  logic [HBIT_W:0]   hbit_tc;
  logic [GAP_W-1:0]  ifrgap_cnt;
  logic [GAP_W-1:0]  transwin_cnt;

  // psc_vld keeps the first compare after reset from restarting the prescaler.
  always_ff @(posedge ic_clk or negedge ic_rst_n) begin
    if (!ic_rst_n) begin
      psc_q   <= '0;
      psc_vld <= 1'b0;
      tx_q    <= 1'b0;
    end else begin
      psc_q   <= psc_usbpdclk;
      psc_vld <= 1'b1;
      tx_q    <= transmit_en;
    end
  end

  assign psc_chg  = psc_vld & (psc_q != psc_usbpdclk);
  assign tx_chg   = tx_q ^ transmit_en;
  assign ifg_qual = wait_en | (rx_wait_en & ic_cc_in);
  assign psc_tc   = PCNT_W'(psc_decode(32'(psc_usbpdclk)));
  assign hbit_tc  = {1'b0, hbitclkdiv} + {{HBIT_W{1'b0}}, hbit_ext};

  apb_ucpd_tick_div #(.W(PCNT_W)) u_psc_div (
    .ic_clk   (ic_clk),
    .ic_rst_n (ic_rst_n),
    .en_in    (enable),
    .clr      (~enable | psc_chg),
    .tc       (psc_tc),
    .fire     (ucpd_fire),
    .tick     (ucpd_tick)
  );

  apb_ucpd_tick_div #(.W(HBIT_W + 1)) u_hbit_div (
    .ic_clk   (ic_clk),
    .ic_rst_n (ic_rst_n),
    .en_in    (ucpd_fire),
    .clr      (~enable | tx_chg),
    .tc       (hbit_tc),
    .fire     (hbit_fire),
    .tick     (hbit_tick)
  );

`ifdef UCPD_HBIT_DITHER_EN
  logic [3:0] frac_acc;
  logic       frac_carry;

  // A carry out of the sixteenths accumulator stretches the next half-bit by one ucpd tick.
  always_ff @(posedge ic_clk or negedge ic_rst_n) begin
    if (!ic_rst_n) begin
      frac_acc   <= '0;
      frac_carry <= 1'b0;
    end else if (!enable || tx_chg) begin
      frac_acc   <= '0;
      frac_carry <= 1'b0;
    end else if (hbit_fire) begin
      {frac_carry, frac_acc} <= {1'b0, frac_acc} + {1'b0, hbit_frac};
    end
  end

  assign hbit_ext = frac_carry;
`else
  logic unused_frac;
  assign unused_frac = ^hbit_frac;
  assign hbit_ext    = 1'b0;
`endif

  always_ff @(posedge ic_clk or negedge ic_rst_n) begin
    if (!ic_rst_n) begin
      bit_phase    <= RST_PHASE;
      bit_tick     <= RST_TICK;
      transwin_en  <= RST_TICK;
      ifrgap_en    <= RST_TICK;
      transwin_cnt <= '0;
      ifrgap_cnt   <= '0;
    end else if (!enable) begin
      bit_phase    <= 1'b0;
      bit_tick     <= 1'b0;
      transwin_en  <= 1'b0;
      ifrgap_en    <= 1'b0;
      transwin_cnt <= '0;
      ifrgap_cnt   <= '0;
    end else begin
      bit_tick    <= 1'b0;
      transwin_en <= 1'b0;
      ifrgap_en   <= 1'b0;

      if (tx_chg) begin
        bit_phase    <= 1'b0;
        transwin_cnt <= '0;
      end else if (hbit_fire) begin
        bit_phase <= ~bit_phase;
        bit_tick  <= bit_phase;
        if (!bmc_en && !wait_en) begin
          if (transwin_cnt <= transwin) begin
            transwin_cnt <= transwin_cnt + 1'b1;
          end else begin
            transwin_cnt <= '0;
            transwin_en  <= 1'b1;
          end
        end
      end

      // End-of-frame completion restarts the gap window and masks a coincident expiry.
      if (tx_eop_cmplt || tx_sop_rst_cmplt) begin
        ifrgap_cnt <= '0;
      end else if (ucpd_fire && ifg_qual) begin
        if (ifrgap_cnt < ifrgap) begin
          ifrgap_cnt <= ifrgap_cnt + 1'b1;
        end else begin
          ifrgap_cnt <= '0;
          ifrgap_en  <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_ucpd_tick_gen.sv
// tb_apb_ucpd_tick_gen -- randomized self-checking bench for apb_ucpd_tick_gen (UCPD_HBIT_DITHER_EN aware). Rev 1.0
`default_nettype none
module tb_apb_ucpd_tick_gen;

  localparam int HBIT_W = 6;
  localparam int GAP_W  = 5;
  localparam int PSC_W  = 3;
`ifdef UCPD_HBIT_DITHER_EN
  localparam int DITHER = 1;
`else
  localparam int DITHER = 0;
`endif

  logic              ic_clk = 1'b0;
  logic              ic_rst_n = 1'b0;
  logic              enable = 1'b0;
  logic [PSC_W-1:0]  psc_usbpdclk = '0;
  logic [HBIT_W-1:0] hbitclkdiv = '0;
  logic [3:0]        hbit_frac = '0;
  logic [GAP_W-1:0]  transwin = '0;
  logic [GAP_W-1:0]  ifrgap = '0;
  logic              transmit_en = 1'b0;
  logic              wait_en = 1'b0;
  logic              bmc_en = 1'b0;
  logic              rx_wait_en = 1'b0;
  logic              ic_cc_in = 1'b0;
  logic              tx_eop_cmplt = 1'b0;
  logic              tx_sop_rst_cmplt = 1'b0;
  logic              ucpd_tick, hbit_tick, bit_tick, bit_phase, transwin_en, ifrgap_en;

  int n_cmp  = 0;
  int n_fail = 0;
  int h1_cyc;
  int h65_cyc;

  apb_ucpd_tick_gen #(.HBIT_W(HBIT_W), .GAP_W(GAP_W), .PSC_W(PSC_W)) dut (
    .ic_clk           (ic_clk),
    .ic_rst_n         (ic_rst_n),
    .enable           (enable),
    .psc_usbpdclk     (psc_usbpdclk),
    .hbitclkdiv       (hbitclkdiv),
    .hbit_frac        (hbit_frac),
    .transwin         (transwin),
    .ifrgap           (ifrgap),
    .transmit_en      (transmit_en),
    .wait_en          (wait_en),
    .bmc_en           (bmc_en),
    .rx_wait_en       (rx_wait_en),
    .ic_cc_in         (ic_cc_in),
    .tx_eop_cmplt     (tx_eop_cmplt),
    .tx_sop_rst_cmplt (tx_sop_rst_cmplt),
    .ucpd_tick        (ucpd_tick),
    .hbit_tick        (hbit_tick),
    .bit_tick         (bit_tick),
    .bit_phase        (bit_phase),
    .transwin_en      (transwin_en),
    .ifrgap_en        (ifrgap_en)
  );

  always #5 ic_clk = ~ic_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge ic_clk);
    #1;
  endtask

  task automatic restart();
    enable = 1'b0;
    step();
    step();
    enable = 1'b1;
  endtask

  task automatic test_reset();
    ic_rst_n = 1'b0;
    enable   = 1'b1;
    step();
    step();
    n_cmp++;
    if ({ucpd_tick, hbit_tick, bit_tick, bit_phase, transwin_en, ifrgap_en} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_hold outputs=%b expected 000000",
               {ucpd_tick, hbit_tick, bit_tick, bit_phase, transwin_en, ifrgap_en});
    end
    enable   = 1'b0;
    ic_rst_n = 1'b1;
    step();
    step();
    n_cmp++;
    if ({ucpd_tick, hbit_tick, bit_tick, bit_phase, transwin_en, ifrgap_en} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_disabled outputs=%b expected 000000",
               {ucpd_tick, hbit_tick, bit_tick, bit_phase, transwin_en, ifrgap_en});
    end
  endtask

  // Half-bit n ends on ucpd tick n*(div+1) + floor((n-1)*frac/16) when dithering.
  task automatic test_tick_chain(input int psc, input int div, input int frac, input int ncyc,
                                 input string name);
    int p, fe, n_next, u, t_next, seen;
    logic eu, eh, eb, ep;
    p  = 1 << psc;
    fe = (DITHER != 0) ? frac : 0;
    psc_usbpdclk = PSC_W'(psc);
    hbitclkdiv   = HBIT_W'(div);
    hbit_frac    = 4'(frac);
    transmit_en  = 1'b0;
    restart();
    n_next  = 1;
    seen    = 0;
    h1_cyc  = -1;
    h65_cyc = -1;
    for (int c = 1; c <= ncyc; c++) begin
      step();
      eu     = (c % p) == 0;
      u      = c / p;
      t_next = n_next * (div + 1) + ((n_next - 1) * fe) / 16;
      eh     = eu && (u == t_next);
      eb     = eh && ((n_next % 2) == 0);
      ep     = (((eh ? n_next : n_next - 1) % 2) == 1);
      if (eh) n_next++;
      if (hbit_tick === 1'b1) begin
        seen++;
        if (seen == 1)  h1_cyc  = c;
        if (seen == 65) h65_cyc = c;
      end
      n_cmp++;
      if ({ucpd_tick, hbit_tick, bit_tick, bit_phase} !== {eu, eh, eb, ep}) begin
        n_fail++;
        if (n_fail <= 20)
          $display("FAIL %s psc=%0d div=%0d frac=%0d cyc=%0d ucpd/hbit/bit/phase got %b expected %b",
                   name, psc, div, frac, c, {ucpd_tick, hbit_tick, bit_tick, bit_phase},
                   {eu, eh, eb, ep});
      end
    end
  endtask

  task automatic test_dither();
    int span;
    test_tick_chain(0, 9, 4, 720, "dither_chain");
    span = h65_cyc - h1_cyc;
    n_cmp++;
    if (h1_cyc < 0 || h65_cyc < 0 || span != 640 + 16 * DITHER) begin
      n_fail++;
      $display("FAIL dither_span 64 hbit ticks took %0d cycles (first=%0d) expected %0d",
               span, h1_cyc, 640 + 16 * DITHER);
    end
  endtask

  task automatic test_ifrgap(input int psc, input int gap, input int eop_at, input bit rnd,
                             input int ncyc, input int exp_first, input string name);
    int p, k, first;
    logic clr, qual, exp_p;
    p = 1 << psc;
    psc_usbpdclk = PSC_W'(psc);
    ifrgap       = GAP_W'(gap);
    wait_en      = !rnd;
    rx_wait_en   = 1'b0;
    ic_cc_in     = 1'b0;
    tx_eop_cmplt = 1'b0;
    tx_sop_rst_cmplt = 1'b0;
    restart();
    k     = 0;
    first = -1;
    for (int c = 1; c <= ncyc; c++) begin
      if (rnd) begin
        wait_en          = ($urandom % 4) == 0;
        rx_wait_en       = 1'($urandom % 2);
        ic_cc_in         = 1'($urandom % 2);
        tx_eop_cmplt     = ($urandom % 12) == 0;
        tx_sop_rst_cmplt = ($urandom % 12) == 0;
      end else begin
        tx_eop_cmplt = (c == eop_at);
      end
      clr  = tx_eop_cmplt | tx_sop_rst_cmplt;
      qual = wait_en | (rx_wait_en & ic_cc_in);
      step();
      exp_p = 1'b0;
      if (clr) begin
        k = 0;
      end else if ((c % p) == 0 && qual) begin
        k++;
        if (k == gap + 1) begin
          exp_p = 1'b1;
          k     = 0;
        end
      end
      if (ifrgap_en === 1'b1 && first < 0) first = c;
      n_cmp++;
      if (ifrgap_en !== exp_p) begin
        n_fail++;
        if (n_fail <= 20)
          $display("FAIL %s psc=%0d gap=%0d cyc=%0d ifrgap_en got %b expected %b",
                   name, psc, gap, c, ifrgap_en, exp_p);
      end
    end
    if (exp_first > 0) begin
      n_cmp++;
      if (first != exp_first) begin
        n_fail++;
        $display("FAIL %s_first first ifrgap_en at cycle %0d expected %0d", name, first, exp_first);
      end
    end
    wait_en = 1'b0; rx_wait_en = 1'b0; ic_cc_in = 1'b0;
    tx_eop_cmplt = 1'b0; tx_sop_rst_cmplt = 1'b0;
  endtask

  task automatic test_transwin(input int div, input int tw, input int tog_at, input bit rnd,
                               input int ncyc, input int exp_first, input string name);
    int hb, twc, first;
    logic tx_prev, txchg, eh, et;
    psc_usbpdclk = '0;
    hbitclkdiv   = HBIT_W'(div);
    hbit_frac    = '0;
    transwin     = GAP_W'(tw);
    bmc_en       = 1'b0;
    wait_en      = 1'b0;
    restart();
    tx_prev = transmit_en;
    hb      = 0;
    twc     = 0;
    first   = -1;
    for (int c = 1; c <= ncyc; c++) begin
      if (rnd) begin
        if (($urandom % 20) == 0) transmit_en = ~transmit_en;
        bmc_en  = ($urandom % 5) == 0;
        wait_en = ($urandom % 6) == 0;
      end else if (c == tog_at) begin
        transmit_en = ~transmit_en;
      end
      txchg   = (transmit_en != tx_prev);
      tx_prev = transmit_en;
      step();
      eh = 1'b0;
      et = 1'b0;
      if (txchg) begin
        hb  = 0;
        twc = 0;
      end else begin
        hb++;
        if (hb == div + 1) begin
          eh = 1'b1;
          hb = 0;
          if (!bmc_en && !wait_en) begin
            twc++;
            if (twc == tw + 2) begin
              et  = 1'b1;
              twc = 0;
            end
          end
        end
      end
      if (transwin_en === 1'b1 && first < 0) first = c;
      n_cmp++;
      if ({hbit_tick, transwin_en} !== {eh, et}) begin
        n_fail++;
        if (n_fail <= 20)
          $display("FAIL %s div=%0d tw=%0d cyc=%0d hbit/transwin_en got %b expected %b",
                   name, div, tw, c, {hbit_tick, transwin_en}, {eh, et});
      end
    end
    if (exp_first > 0) begin
      n_cmp++;
      if (first != exp_first) begin
        n_fail++;
        $display("FAIL %s_first first transwin_en at cycle %0d expected %0d", name, first, exp_first);
      end
    end
    bmc_en = 1'b0; wait_en = 1'b0; transmit_en = 1'b0;
  endtask

  task automatic test_psc_change();
    int r;
    logic eu;
    psc_usbpdclk = 3'd1;
    hbitclkdiv   = '0;
    restart();
    r = $urandom_range(3, 9);
    for (int c = 1; c <= r; c++) begin
      step();
      eu = (c % 2) == 0;
      n_cmp++;
      if (ucpd_tick !== eu) begin
        n_fail++;
        $display("FAIL psc_before cyc=%0d ucpd_tick got %b expected %b", c, ucpd_tick, eu);
      end
    end
    psc_usbpdclk = 3'd2;
    for (int j = 0; j <= 12; j++) begin
      step();
      eu = (j > 0) && ((j % 4) == 0);
      n_cmp++;
      if (ucpd_tick !== eu) begin
        n_fail++;
        $display("FAIL psc_after offset=%0d ucpd_tick got %b expected %b", j, ucpd_tick, eu);
      end
    end
  endtask

  task automatic test_enable_off();
    psc_usbpdclk = '0;
    hbitclkdiv   = '0;
    restart();
    for (int c = 0; c < 5; c++) step();
    enable = 1'b0;
    step();
    n_cmp++;
    if ({ucpd_tick, hbit_tick, bit_tick, bit_phase, transwin_en, ifrgap_en} !== 6'b0) begin
      n_fail++;
      $display("FAIL enable_off outputs=%b expected 000000",
               {ucpd_tick, hbit_tick, bit_tick, bit_phase, transwin_en, ifrgap_en});
    end
    enable = 1'b1;
    step();
    n_cmp++;
    if ({ucpd_tick, hbit_tick, bit_tick, bit_phase} !== 4'b1101) begin
      n_fail++;
      $display("FAIL enable_restart ucpd/hbit/bit/phase got %b expected 1101",
               {ucpd_tick, hbit_tick, bit_tick, bit_phase});
    end
  endtask

  task automatic test_reset_mid();
    logic eu, eh, eb, ep;
    psc_usbpdclk = 3'd2;
    hbitclkdiv   = 6'd2;
    hbit_frac    = '0;
    transmit_en  = 1'b0;
    restart();
    for (int c = 1; c <= 12; c++) step();
    n_cmp++;
    if (hbit_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_pre hbit_tick got %b expected 1", hbit_tick);
    end
    #1 ic_rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ucpd_tick, hbit_tick, bit_tick, bit_phase, transwin_en, ifrgap_en} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_async outputs=%b expected 000000",
               {ucpd_tick, hbit_tick, bit_tick, bit_phase, transwin_en, ifrgap_en});
    end
    step();
    step();
    ic_rst_n = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      step();
      eu = (c % 4) == 0;
      eh = (c % 12) == 0;
      eb = (c % 24) == 0;
      ep = ((c / 12) % 2) == 1;
      n_cmp++;
      if ({ucpd_tick, hbit_tick, bit_tick, bit_phase} !== {eu, eh, eb, ep}) begin
        n_fail++;
        if (n_fail <= 20)
          $display("FAIL reset_restart cyc=%0d ucpd/hbit/bit/phase got %b expected %b",
                   c, {ucpd_tick, hbit_tick, bit_tick, bit_phase}, {eu, eh, eb, ep});
      end
    end
  endtask

  initial begin
    test_reset();
    test_tick_chain(3, 4, 0, 400, "psc3_div4");
    test_tick_chain(0, 0, 0, 40, "psc0_div0");
    for (int i = 0; i < 4; i++)
      test_tick_chain(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 15)), 300, "rand_chain");
    test_dither();
    test_ifrgap(1, 3, 0, 1'b0, 12, 8, "ifrgap_fixed");
    test_ifrgap(1, 3, 5, 1'b0, 14, 12, "ifrgap_eop");
    for (int i = 0; i < 3; i++)
      test_ifrgap(int'($urandom_range(0, 2)), int'($urandom_range(0, 7)), 0, 1'b1, 200, 0,
                  "ifrgap_rand");
    test_transwin(1, 2, 0, 1'b0, 10, 8, "transwin_fixed");
    test_transwin(1, 2, 4, 1'b0, 14, 12, "transwin_toggle");
    for (int i = 0; i < 3; i++)
      test_transwin(int'($urandom_range(0, 3)), int'($urandom_range(0, 5)), 0, 1'b1, 200, 0,
                    "transwin_rand");
    test_psc_change();
    test_enable_off();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
